// File: rtl/ddr5_cmd_responder_pkg.sv
// Shared declarations for the DDR5 command responder: command and slot
// encodings, violation codes, default timing and counter helpers.
package ddr5_cmd_responder_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_BURST = 2'd2
  } slot_t;

  localparam logic [3:0] VIOL_NONE       = 4'd0;
  localparam logic [3:0] VIOL_ACT_OPEN   = 4'd1;
  localparam logic [3:0] VIOL_ACT_TRP    = 4'd2;
  localparam logic [3:0] VIOL_RW_CLOSED  = 4'd3;
  localparam logic [3:0] VIOL_RW_TRCD    = 4'd4;
  localparam logic [3:0] VIOL_PRE_TRAS   = 4'd5;
  localparam logic [3:0] VIOL_REFRESHING = 4'd6;
  localparam logic [3:0] VIOL_REF_BUSY   = 4'd7;
  localparam logic [3:0] VIOL_SLOT_BUSY  = 4'd8;
  localparam logic [3:0] VIOL_ENCODING   = 4'd9;

  localparam int DEF_T_RCD   = 39;
  localparam int DEF_T_RP    = 39;
  localparam int DEF_T_RAS   = 76;
  localparam int DEF_T_CL    = 40;
  localparam int DEF_T_CWD   = 38;
  localparam int DEF_T_BURST = 8;
  localparam int DEF_T_RFC   = 295;

  localparam int CNT_W = 16;

  // A constraint of t cycles is met once the counter reads 0; because the
  // counter is first visible the cycle after loading, it is loaded with t-1.
  function automatic logic [CNT_W-1:0] load_val(input int t);
    return (t > 0) ? CNT_W'(t - 1) : '0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

endpackage

// File: rtl/ddr5_bank_tracker.sv
// One DRAM bank: open/closed state, open row, and tRCD/tRAS/tRP timers.
// The parent only pulses act/pre for commands it has already judged legal.
module ddr5_bank_tracker
  import ddr5_cmd_responder_pkg::*;
#(
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RAS = DEF_T_RAS,
  parameter int T_RP  = DEF_T_RP
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        act,
  input  logic        pre,
  input  logic [15:0] act_row,
  output logic        is_open,
  output logic [15:0] row,
  output logic        rcd_done,
  output logic        ras_done,
  output logic        rp_done
);

  logic [CNT_W-1:0] rcd_cnt;
  logic [CNT_W-1:0] ras_cnt;
  logic [CNT_W-1:0] rp_cnt;

  // Bank state update with free-running saturating timers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      is_open <= 1'b0;
      row     <= '0;
      rcd_cnt <= '0;
      ras_cnt <= '0;
      rp_cnt  <= '0;
    end else begin
      rcd_cnt <= sat_dec(rcd_cnt);
      ras_cnt <= sat_dec(ras_cnt);
      rp_cnt  <= sat_dec(rp_cnt);
      if (act) begin
        is_open <= 1'b1;
        row     <= act_row;
        rcd_cnt <= load_val(T_RCD);
        ras_cnt <= load_val(T_RAS);
      end
      if (pre) begin
        is_open <= 1'b0;
        rp_cnt  <= load_val(T_RP);
      end
    end
  end

  assign rcd_done = (rcd_cnt == '0);
  assign ras_done = (ras_cnt == '0);
  assign rp_done  = (rp_cnt == '0);

endmodule

// File: rtl/ddr5_cmd_responder.sv
// DDR5 command responder: checks each command against per-bank timing,
// the single data slot and the refresh window, then either applies it or
// reports a one-cycle violation. Reads return synthetic beats, writes are
// folded into a checksum.
//
// state      | meaning
// SLOT_IDLE  | no burst pending, RD/WR may be accepted
// SLOT_WAIT  | burst accepted, counting down CL or CWD latency
// SLOT_BURST | presenting T_BURST beats (rd_valid or wr_ready)
module ddr5_cmd_responder
  import ddr5_cmd_responder_pkg::*;
#(
  parameter int NUM_BG  = 8,
  parameter int NUM_BA  = 4,
  parameter int T_RCD   = DEF_T_RCD,
  parameter int T_RP    = DEF_T_RP,
  parameter int T_RAS   = DEF_T_RAS,
  parameter int T_CL    = DEF_T_CL,
  parameter int T_CWD   = DEF_T_CWD,
  parameter int T_BURST = DEF_T_BURST,
  parameter int T_RFC   = DEF_T_RFC
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  input  logic [2:0]               cmd,
  input  logic [2:0]               cmd_bg,
  input  logic [1:0]               cmd_ba,
  input  logic [15:0]              cmd_row,
  input  logic [9:0]               cmd_col,
  input  logic [63:0]              wr_data,
  output logic                     wr_ready,
  output logic                     rd_valid,
  output logic [63:0]              rd_data,
  output logic [NUM_BG*NUM_BA-1:0] bank_open,
  output logic                     viol,
  output logic [3:0]               viol_code,
  output logic                     refreshing
);

  localparam int NB = NUM_BG * NUM_BA;
  // Slot enters WAIT the cycle after issue, so WAIT lasts latency-1 cycles.
  localparam logic [CNT_W-1:0] RD_WAIT    = load_val(T_CL - 1);
  localparam logic [CNT_W-1:0] WR_WAIT    = load_val(T_CWD - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(T_BURST - 1);
  localparam logic [CNT_W-1:0] RFC_LOAD   = CNT_W'(T_RFC);

  cmd_t             cmd_e;
  int               sel_idx;
  logic [NB-1:0]    b_open, rcd_done, ras_done, rp_done, act_sel, pre_sel;
  logic [15:0]      b_row [NB];
  logic             sel_open, sel_rcd_done, sel_ras_done, sel_rp_done;
  logic [15:0]      sel_row;
  logic             is_cmd, accept, all_idle, slot_busy, start_rd, start_wr;
  logic [3:0]       code;

  slot_t            slot_q, slot_d;
  logic [CNT_W-1:0] lat_q, lat_d, beat_q, beat_d, rfc_cnt;
  logic             op_rd_q;
  logic [2:0]       bg_q;
  logic [1:0]       ba_q;
  logic [15:0]      row_q;
  logic [9:0]       col_q;
  logic [63:0]      checksum;

  assign cmd_e   = cmd_t'(cmd);
  assign sel_idx = int'(cmd_bg) * NUM_BA + int'(cmd_ba);

  for (genvar g = 0; g < NB; g++) begin : g_bank
    ddr5_bank_tracker #(
      .T_RCD(T_RCD),
      .T_RAS(T_RAS),
      .T_RP (T_RP)
    ) u_bank (
      .clock   (clock),
      .reset_n (reset_n),
      .act     (act_sel[g]),
      .pre     (pre_sel[g]),
      .act_row (cmd_row),
      .is_open (b_open[g]),
      .row     (b_row[g]),
      .rcd_done(rcd_done[g]),
      .ras_done(ras_done[g]),
      .rp_done (rp_done[g])
    );
  end

  assign bank_open  = b_open;
  assign refreshing = (rfc_cnt != '0);
  assign slot_busy  = (slot_q != SLOT_IDLE);
  assign all_idle   = (b_open == '0) && (&rp_done);

  // Status of the addressed bank.
  always_comb begin
    sel_open     = 1'b0;
    sel_rcd_done = 1'b0;
    sel_ras_done = 1'b0;
    sel_rp_done  = 1'b0;
    sel_row      = '0;
    for (int i = 0; i < NB; i++) begin
      if (sel_idx == i) begin
        sel_open     = b_open[i];
        sel_rcd_done = rcd_done[i];
        sel_ras_done = ras_done[i];
        sel_rp_done  = rp_done[i];
        sel_row      = b_row[i];
      end
    end
  end

  // Rule check; the lowest applicable code wins, refresh overrides all.
  always_comb begin
    is_cmd = cmd_valid && (cmd_e != CMD_NOP);
    code   = VIOL_NONE;
    if (is_cmd) begin
      if (refreshing) begin
        code = VIOL_REFRESHING;
      end else begin
        case (cmd_e)
          CMD_ACT: begin
            if (sel_open)          code = VIOL_ACT_OPEN;
            else if (!sel_rp_done) code = VIOL_ACT_TRP;
          end
          CMD_RD, CMD_WR: begin
            if (!sel_open)          code = VIOL_RW_CLOSED;
            else if (!sel_rcd_done) code = VIOL_RW_TRCD;
            else if (slot_busy)     code = VIOL_SLOT_BUSY;
          end
          CMD_PRE: begin
            if (sel_open && !sel_ras_done) code = VIOL_PRE_TRAS;
          end
          CMD_REF: begin
            if (!all_idle) code = VIOL_REF_BUSY;
          end
          default: code = VIOL_ENCODING;
        endcase
      end
    end
    accept   = is_cmd && (code == VIOL_NONE);
    start_rd = accept && (cmd_e == CMD_RD);
    start_wr = accept && (cmd_e == CMD_WR);
  end

  // Per-bank strobes for accepted ACT/PRE; PRE to a closed bank does nothing.
  always_comb begin
    act_sel = '0;
    pre_sel = '0;
    for (int i = 0; i < NB; i++) begin
      act_sel[i] = accept && (cmd_e == CMD_ACT) && (sel_idx == i);
      pre_sel[i] = accept && (cmd_e == CMD_PRE) && (sel_idx == i) && b_open[i];
    end
  end

  // Data slot next-state logic.
  always_comb begin
    slot_d = slot_q;
    lat_d  = lat_q;
    beat_d = beat_q;
    case (slot_q)
      SLOT_IDLE: begin
        if (start_rd || start_wr) begin
          slot_d = SLOT_WAIT;
          lat_d  = start_rd ? RD_WAIT : WR_WAIT;
        end
      end
      SLOT_WAIT: begin
        if (lat_q == '0) begin
          slot_d = SLOT_BURST;
          beat_d = '0;
        end else begin
          lat_d = sat_dec(lat_q);
        end
      end
      SLOT_BURST: begin
        if (beat_q == BURST_LAST) slot_d = SLOT_IDLE;
        else                      beat_d = beat_q + CNT_W'(1);
      end
      default: slot_d = SLOT_IDLE;
    endcase
  end

  // Data slot state register and captured burst target.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_q  <= SLOT_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      op_rd_q <= 1'b0;
      bg_q    <= '0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      slot_q <= slot_d;
      lat_q  <= lat_d;
      beat_q <= beat_d;
      if (start_rd || start_wr) begin
        op_rd_q <= start_rd;
        bg_q    <= cmd_bg;
        ba_q    <= cmd_ba;
        row_q   <= sel_row;
        col_q   <= cmd_col;
      end
    end
  end

  // Refresh window, write checksum and registered violation report.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rfc_cnt   <= '0;
      checksum  <= '0;
      viol      <= 1'b0;
      viol_code <= VIOL_NONE;
    end else begin
      if (accept && (cmd_e == CMD_REF)) rfc_cnt <= RFC_LOAD;
      else                              rfc_cnt <= sat_dec(rfc_cnt);
      if (wr_ready) checksum <= checksum ^ wr_data;
      viol      <= (code != VIOL_NONE);
      viol_code <= code;
    end
  end

  assign rd_valid = (slot_q == SLOT_BURST) && op_rd_q;
  assign wr_ready = (slot_q == SLOT_BURST) && !op_rd_q;
  assign rd_data  = rd_valid ? 64'({bg_q, ba_q, row_q, col_q, beat_q[2:0]}) : '0;

endmodule

// File: tb/tb_ddr5_cmd_responder.sv
// Scoreboard bench for ddr5_cmd_responder: the driver applies directed and
// random commands and a timestamp-based model pushes expected viol, read
// beats and write-ready cycles; a negedge monitor pops and compares.
module tb_ddr5_cmd_responder;
  import ddr5_cmd_responder_pkg::*;

  localparam int NUM_BG = 8, NUM_BA = 4, NB = 32;
  localparam int T_RCD = 39, T_RP = 39, T_RAS = 76, T_CL = 40;
  localparam int T_CWD = 38, T_BURST = 8, T_RFC = 295;
  localparam int NEG = -100000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd = '0;
  logic [2:0]    cmd_bg = '0;
  logic [1:0]    cmd_ba = '0;
  logic [15:0]   cmd_row = '0;
  logic [9:0]    cmd_col = '0;
  logic [63:0]   wr_data = '0;
  logic          wr_ready, rd_valid, viol, refreshing;
  logic [63:0]   rd_data;
  logic [NB-1:0] bank_open;
  logic [3:0]    viol_code;

  ddr5_cmd_responder #(
    .NUM_BG(NUM_BG), .NUM_BA(NUM_BA), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
    .T_CL(T_CL), .T_CWD(T_CWD), .T_BURST(T_BURST), .T_RFC(T_RFC)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .bank_open(bank_open), .viol(viol), .viol_code(viol_code), .refreshing(refreshing)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int cyc; logic [63:0] data;} exp_t;
  typedef exp_t exp_q_t[$];

  exp_q_t rd_q, wr_q, viol_q;
  bit          m_open [NB];
  int          m_act  [NB];
  int          m_pre  [NB];
  logic [15:0] m_row  [NB];
  int  slot_last = -1;
  int  ref_last  = -1;
  int  n_cmp = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic exp_q_t purge(input exp_q_t q, input int t);
    exp_q_t r;
    foreach (q[i]) if (q[i].cyc <= t) r.push_back(q[i]);
    return r;
  endfunction

  // Reference model: legality from elapsed time since each bank's last
  // ACT/PRE, the last busy cycle of the data slot and the refresh window.
  task automatic model_cmd(input int t, input int c, input int bg, input int ba,
                           input logic [15:0] row, input logic [9:0] col);
    int b;
    int code;
    exp_t e;
    b = bg * NUM_BA + ba;
    code = 0;
    if (c == 0) return;
    if (t <= ref_last) code = 6;
    else begin
      case (c)
        1: if (m_open[b]) code = 1; else if (t - m_pre[b] < T_RP) code = 2;
        2, 3: begin
          if (!m_open[b]) code = 3;
          else if (t - m_act[b] < T_RCD) code = 4;
          else if (t <= slot_last) code = 8;
        end
        4: if (m_open[b] && (t - m_act[b] < T_RAS)) code = 5;
        5: for (int i = 0; i < NB; i++) if (m_open[i] || (t - m_pre[i] < T_RP)) code = 7;
        default: code = 9;
      endcase
    end
    if (code != 0) begin
      e.cyc = t + 1; e.data = 64'(code);
      viol_q.push_back(e);
      return;
    end
    case (c)
      1: begin m_open[b] = 1'b1; m_act[b] = t; m_row[b] = row; end
      2: begin
        for (int k = 0; k < T_BURST; k++) begin
          e.cyc = t + T_CL + k;
          e.data = {30'd0, 3'(bg), 2'(ba), m_row[b], col, 3'(k)};
          rd_q.push_back(e);
        end
        slot_last = t + T_CL + T_BURST - 1;
      end
      3: begin
        for (int k = 0; k < T_BURST; k++) begin
          e.cyc = t + T_CWD + k; e.data = '0;
          wr_q.push_back(e);
        end
        slot_last = t + T_CWD + T_BURST - 1;
      end
      4: if (m_open[b]) begin m_open[b] = 1'b0; m_pre[b] = t; end
      5: ref_last = t + T_RFC;
      default: ;
    endcase
  endtask

  task automatic model_reset(input int t);
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0; m_act[i] = NEG; m_pre[i] = NEG; m_row[i] = '0;
    end
    slot_last = t;
    ref_last  = t;
    rd_q   = purge(rd_q, t);
    wr_q   = purge(wr_q, t);
    viol_q = purge(viol_q, t);
  endtask

  task automatic drive(input bit v, input int c, input int bg, input int ba,
                       input logic [15:0] row, input logic [9:0] col);
    @(negedge clock); #1;
    reset_n   = 1'b1;
    cmd_valid = v;
    cmd       = 3'(c);
    cmd_bg    = 3'(bg);
    cmd_ba    = 2'(ba);
    cmd_row   = row;
    cmd_col   = col;
    wr_data   = {$urandom, $urandom};
    if (v) model_cmd(cyc, c, bg, ba, row, col);
  endtask

  task automatic idle_until(input int t);
    while (cyc + 1 < t)
      drive(1'b0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
            16'($urandom), 10'($urandom));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock); #1;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      model_reset(cyc);
    end
  endtask

  task automatic rand_cycle();
    int r, bg, ba;
    r  = $urandom_range(0, 99);
    bg = $urandom_range(0, 1);
    ba = $urandom_range(0, 3);
    if (r < 40)      drive(1'b0, $urandom_range(0, 7), bg, ba, 16'($urandom), 10'($urandom));
    else if (r < 43) drive(1'b1, 0, bg, ba, 16'($urandom), 10'($urandom));
    else if (r < 58) drive(1'b1, 1, bg, ba, 16'($urandom), 10'($urandom));
    else if (r < 72) drive(1'b1, 2, bg, ba, 16'($urandom), 10'($urandom));
    else if (r < 82) drive(1'b1, 3, bg, ba, 16'($urandom), 10'($urandom));
    else if (r < 95) drive(1'b1, 4, bg, ba, 16'($urandom), 10'($urandom));
    else if (r < 97) drive(1'b1, 5, bg, ba, 16'($urandom), 10'($urandom));
    else             drive(1'b1, $urandom_range(6, 7), bg, ba, 16'($urandom), 10'($urandom));
  endtask

  // Monitor: compares every observable output each cycle against the model.
  logic [NB-1:0] eo;
  bit            en;
  exp_t          em;
  always @(negedge clock) begin
    if (mon_en) begin
      for (int i = 0; i < NB; i++) eo[i] = m_open[i];
      check("bank_open", 64'(bank_open), 64'(eo));
      check("refreshing", 64'(refreshing), 64'(cyc <= ref_last));

      en = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
      check("rd_valid", 64'(rd_valid), 64'(en));
      if (en) begin
        em = rd_q.pop_front();
        check("rd_data", rd_data, em.data);
      end

      en = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
      check("wr_ready", 64'(wr_ready), 64'(en));
      if (en) em = wr_q.pop_front();

      en = (viol_q.size() > 0) && (viol_q[0].cyc == cyc);
      check("viol", 64'(viol), 64'(en));
      if (en) begin
        em = viol_q.pop_front();
        check("viol_code", 64'(viol_code), em.data);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t0;
  initial begin
    do_reset(3);
    mon_en = 1'b1;
    drive(1'b0, 0, 0, 0, '0, '0);
    check("reset_rd_data", rd_data, 64'd0);
    check("reset_viol_code", 64'(viol_code), 64'd0);
    check("reset_wr_ready", 64'(wr_ready), 64'd0);

    // Read after tRCD: beats at +40..+47.
    t0 = cyc + 1;
    idle_until(t0);     drive(1'b1, 1, 0, 0, 16'h0012, '0);
    idle_until(t0 + 39); drive(1'b1, 2, 0, 0, '0, 10'h005);
    idle_until(t0 + 100);

    // Read before tRCD.
    t0 = cyc + 1;
    idle_until(t0);     drive(1'b1, 1, 0, 1, 16'h0abc, '0);
    idle_until(t0 + 20); drive(1'b1, 2, 0, 1, '0, 10'h001);
    idle_until(t0 + 80);

    // PRE before tRAS, PRE at tRAS, ACT before/at tRP.
    t0 = cyc + 1;
    idle_until(t0);      drive(1'b1, 1, 1, 0, 16'h1111, '0);
    idle_until(t0 + 50);  drive(1'b1, 4, 1, 0, '0, '0);
    idle_until(t0 + 76);  drive(1'b1, 4, 1, 0, '0, '0);
    idle_until(t0 + 100); drive(1'b1, 1, 1, 0, 16'h2222, '0);
    idle_until(t0 + 115); drive(1'b1, 1, 1, 0, 16'h3333, '0);
    idle_until(t0 + 150);

    // Write latency and slot-busy read to another open bank.
    t0 = cyc + 1;
    idle_until(t0);     drive(1'b1, 1, 2, 0, 16'h4444, '0);
    idle_until(t0 + 39); drive(1'b1, 3, 2, 0, '0, 10'h010);
    idle_until(t0 + 45); drive(1'b1, 2, 0, 0, '0, 10'h020);
    idle_until(t0 + 100);

    // Close everything, refresh, command during refresh, illegal encoding.
    for (int i = 0; i < NB; i++) drive(1'b1, 4, i / NUM_BA, i % NUM_BA, '0, '0);
    t0 = cyc + T_RP + 2;
    idle_until(t0);      drive(1'b1, 5, 0, 0, '0, '0);
    idle_until(t0 + 10);  drive(1'b1, 1, 3, 3, 16'h5555, '0);
    idle_until(t0 + 295); drive(1'b1, 2, 3, 3, '0, '0);
    idle_until(t0 + 300); drive(1'b1, 7, 0, 0, '0, '0);
    idle_until(t0 + 310);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) rand_cycle();
    idle_until(cyc + 400);

    // Reset during read beat 3 aborts the burst.
    do_reset(2);
    t0 = cyc + 2;
    idle_until(t0);      drive(1'b1, 1, 3, 2, 16'hbeef, '0);
    idle_until(t0 + 39);  drive(1'b1, 2, 3, 2, '0, 10'h3ff);
    idle_until(t0 + 39 + T_CL + 3);
    do_reset(1);
    idle_until(cyc + 40);

    check("pending_rd", 64'(rd_q.size()), 64'd0);
    check("pending_wr", 64'(wr_q.size()), 64'd0);
    check("pending_viol", 64'(viol_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr5_cmd_responder.md
DDR5_CMD_RESPONDER -- requirements
Module: ddr5_cmd_responder

Interface
REQ-001 Parameter NUM_BG, default 8, meaning bank groups.
REQ-002 Parameter NUM_BA, default 4, meaning banks per group; total banks NB = NUM_BG*NUM_BA.
REQ-003 Parameters T_RCD=39, T_RP=39, T_RAS=76, T_CL=40, T_CWD=38, T_BURST=8, T_RFC=295, all in clock cycles.
REQ-004 Single clock; reset is synchronous and active-low; ports are named clock and reset_n.
REQ-005 clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 cmd_valid  in  1  command present this cycle.
REQ-008 cmd  in  3  cmd_t: NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5; codes 6 and 7 are illegal.
REQ-009 cmd_bg  in  3, cmd_ba  in  2, cmd_row  in  16, cmd_col  in  10  command target.
REQ-010 wr_data  in  64  write beat, sampled while wr_ready=1.
REQ-011 wr_ready  out  1  high for each of the T_BURST write-beat cycles.
REQ-012 rd_valid  out  1, rd_data  out  64  read beat.
REQ-013 bank_open  out  NB  per-bank open-row flag, index = bg*NUM_BA+ba.
REQ-014 viol  out  1  one-cycle pulse when a command breaks a rule.
REQ-015 viol_code  out  4  reason for the violation; valid only while viol=1.
REQ-016 refreshing  out  1  high during the T_RFC window.

Function
REQ-017 Each bank SHALL have its own state (IDLE, ACTIVE), open row, tRCD/tRAS/tRP down-counters, and saturating-at-0 decrement every cycle.
REQ-018 ACT to an IDLE bank with tRP=0 SHALL open cmd_row, set bank_open next cycle, and load tRCD=T_RCD and tRAS=T_RAS.
REQ-019 PRE to an ACTIVE bank with tRAS=0 SHALL close the bank and load tRP=T_RP; PRE to an IDLE bank is a legal NOP.
REQ-020 RD/WR SHALL be legal only to an ACTIVE bank with tRCD=0 and an idle data slot.
REQ-021 A legal RD issued at cycle t SHALL produce rd_valid during cycles t+T_CL through t+T_CL+T_BURST-1.
REQ-022 rd_data beat k SHALL be the zero-extended concatenation {bg, ba, open row, col, k[2:0]}, i.e. 34 bits.
REQ-023 A legal WR issued at cycle t SHALL assert wr_ready during cycles t+T_CWD through t+T_CWD+T_BURST-1; each beat is accepted and XOR-folded into an internal checksum (no storage).
REQ-024 The data slot is a single pending burst: state SLOT_IDLE -> SLOT_WAIT (latency count) -> SLOT_BURST (T_BURST beats) -> SLOT_IDLE; it is busy from command issue until the last beat.
REQ-025 REF SHALL be legal only when every bank is IDLE with tRP=0; it asserts refreshing for T_RFC cycles, starting the cycle after the REF.
REQ-026 An illegal command SHALL change no state, pulse viol the next cycle, and report the viol_code defined in REQ-027.
REQ-027 viol_code values: 1=ACT to open bank, 2=ACT before tRP, 3=RD/WR to closed bank, 4=RD/WR before tRCD, 5=PRE before tRAS, 6=any non-NOP command while refreshing, 7=REF with a bank open or in tRP, 8=RD/WR while data slot busy, 9=illegal encoding.
REQ-028 When several violation conditions apply, the lowest code SHALL win, except that 6 overrides all others.
REQ-029 cmd_valid=0 or cmd=NOP SHALL be ignored, with no viol.
REQ-030 A command in the cycle the last burst beat completes SHALL see the slot busy; the slot frees the following cycle.

Reset
REQ-031 While reset_n=0 at a clock edge, all banks SHALL go IDLE with counters 0, the slot SHALL go SLOT_IDLE, the refresh counter SHALL go to 0, and the checksum SHALL clear.
REQ-032 Outputs SHALL be 0 in the cycle after reset: bank_open, rd_valid, rd_data, wr_ready, viol, viol_code, refreshing.
REQ-033 A reset arriving mid-burst or mid-refresh SHALL abort it, and no beat is emitted after reset.

Structure
REQ-034 cmd_t, slot state enum, viol_code constants, and default timing values SHALL live in the shared declarations package.
REQ-035 Per-bank logic SHALL be one sub-module, ddr5_bank_tracker, instantiated NB times via generate.

Verification
REQ-036 Reset, then ACT bg0/ba0 row 0x12 at cycle 0 and RD col 0x5 at cycle 39 -> rd_valid cycles 79-86, beat 0 rd_data = {3'd0, 2'd0, 16'h0012, 10'h005, 3'd0}.
REQ-037 ACT at cycle 0, then RD to the same bank at cycle 20 -> viol=1 with viol_code=4 at cycle 21, and no rd_valid.
REQ-038 ACT at cycle 0, PRE at cycle 50 -> code 5; PRE at cycle 76 -> bank_open clears; ACT at cycle 100 -> code 2; ACT at cycle 115 -> accepted.
REQ-039 WR issued at cycle 39 after ACT at cycle 0 -> wr_ready cycles 77-84; a second RD to another open bank at cycle 45 -> code 8.
REQ-040 REF with all banks idle -> refreshing high for 295 cycles; ACT during refresh -> code 6; cmd=7 after refresh -> code 9.
REQ-041 reset_n=0 asserted during read beat 3 -> rd_valid and bank_open are 0 the next cycle and stay 0.
